// File: rtl/frame_source_ctrl_if.sv
// frame_source_ctrl_if: source/scan events in, frame-buffer control and status out
interface frame_source_ctrl_if;
   logic       mode_req;
   logic       frame_valid_uart;
   logic       frame_valid_default;
   logic       scan_done;
   logic       sel_uart;
   logic       load;
   logic       gen_enable;
   logic       uart_active;
   logic [7:0] dropped;
   modport master (
      output mode_req, frame_valid_uart, frame_valid_default, scan_done,
      input  sel_uart, load, gen_enable, uart_active, dropped
   );
   modport slave (
      input  mode_req, frame_valid_uart, frame_valid_default, scan_done,
      output sel_uart, load, gen_enable, uart_active, dropped
   );
endinterface

// File: rtl/frame_source_ctrl.sv
// frame_source_ctrl: picks UART or default animation and loads the frame buffer only at cube-scan boundaries
module frame_source_ctrl #(
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int CNT_W          = 26
) (
   input logic clk,
   input logic rst,
   frame_source_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_DEF, S_WAIT, S_UART} state_t;
   state_t           state_q, state_d;
   logic             sync_q, mode_s_q;
   logic             pend_uart_q, pend_uart_d, pend_def_q, pend_def_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_q, load_d, sel_q, sel_d, gen_q, gen_d;
   logic [7:0]       drop_q, drop_d;
   logic             fvu, fvd, in_uart, timeout, sel_pend, sel_valid, do_load;
   assign fvu = bus.frame_valid_uart;
   assign fvd = bus.frame_valid_default;
   always_comb begin
      in_uart   = state_q == S_UART;
      timeout   = in_uart && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1) && !fvu;
      state_d   = !mode_s_q                      ? S_DEF  :
                  state_q == S_DEF               ? S_WAIT :
                  (state_q == S_WAIT && fvu)     ? S_UART :
                  timeout                        ? S_WAIT : state_q;
      sel_pend  = in_uart ? pend_uart_q : pend_def_q;
      sel_valid = in_uart ? fvu : fvd;
      // a load on a state-change edge would let sel_uart move under the strobe, so it waits
      do_load   = bus.scan_done && sel_pend && state_d == state_q;
      pend_uart_d = fvu || (pend_uart_q && !(do_load && in_uart));
      pend_def_d  = fvd || (pend_def_q && !(do_load && !in_uart));
      drop_d    = drop_q + 8'(sel_valid && sel_pend && !do_load && drop_q != 8'hff);
      cnt_d     = (fvu || (state_d == S_UART && !in_uart)) ? '0 :
                  in_uart ? cnt_q + 1'b1 : cnt_q;
      load_d    = do_load;
      sel_d     = state_d == S_UART;
      gen_d     = state_d != S_UART;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= 1'b0;
         mode_s_q    <= 1'b0;
         state_q     <= S_DEF;
         pend_uart_q <= 1'b0;
         pend_def_q  <= 1'b0;
         cnt_q       <= '0;
         load_q      <= 1'b0;
         sel_q       <= 1'b0;
         gen_q       <= 1'b1;
         drop_q      <= '0;
      end else begin
         sync_q      <= bus.mode_req;
         mode_s_q    <= sync_q;
         state_q     <= state_d;
         pend_uart_q <= pend_uart_d;
         pend_def_q  <= pend_def_d;
         cnt_q       <= cnt_d;
         load_q      <= load_d;
         sel_q       <= sel_d;
         gen_q       <= gen_d;
         drop_q      <= drop_d;
      end
   end
   assign bus.sel_uart    = sel_q;
   assign bus.uart_active = sel_q;
   assign bus.gen_enable  = gen_q;
   assign bus.load        = load_q;
   assign bus.dropped     = drop_q;
endmodule

// File: tb/tb_frame_source_ctrl.sv
// tb_frame_source_ctrl: scoreboard bench; expected loads queued at stimulus, checked cycle-exact on output
module tb_frame_source_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   typedef struct {int cyc; logic sel;} exp_t;
   exp_t exp_q[$];
   frame_source_ctrl_if bus();
   frame_source_ctrl #(.TIMEOUT_CYCLES(100), .CNT_W(7)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask
   // every cycle: either the queued load appears with the right select, or load stays low
   always @(negedge clk) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         chk("load", 32'(bus.load), 1);
         chk("load_sel", 32'(bus.sel_uart), 32'(exp_q[0].sel));
         void'(exp_q.pop_front());
      end else
         chk("no_load", 32'(bus.load), 0);
   end
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic pulse(input logic u, input logic d, input logic s, input bit exp_load, input logic exp_sel);
      bus.frame_valid_uart    = u;
      bus.frame_valid_default = d;
      bus.scan_done           = s;
      if (exp_load) exp_q.push_back('{cyc + 1, exp_sel});
      @(negedge clk);
      bus.frame_valid_uart    = 1'b0;
      bus.frame_valid_default = 1'b0;
      bus.scan_done           = 1'b0;
   endtask
   task automatic reset_pulse(input string tag);
      rst = 1'b1;
      @(negedge clk);
      chk({tag, "_sel"}, 32'(bus.sel_uart), 0);
      chk({tag, "_ua"}, 32'(bus.uart_active), 0);
      chk({tag, "_load"}, 32'(bus.load), 0);
      chk({tag, "_gen"}, 32'(bus.gen_enable), 1);
      chk({tag, "_drop"}, 32'(bus.dropped), 0);
      rst = 1'b0;
   endtask
   // with mode_req held at 1, S_WAIT is reached on the 3rd edge after reset, so a UART valid
   // on that edge is too early and one on the next edge enters S_UART
   task automatic reenter(input string tag);
      idle(2);
      pulse(1, 0, 0, 0, 0);
      chk({tag, "_early"}, 32'(bus.sel_uart), 0);
      pulse(1, 0, 0, 0, 0);
      chk({tag, "_sel"}, 32'(bus.sel_uart), 1);
      chk({tag, "_gen"}, 32'(bus.gen_enable), 0);
   endtask
   initial begin
      rst = 1'b1;
      bus.mode_req = 1'b0;
      bus.frame_valid_uart = 1'b0;
      bus.frame_valid_default = 1'b0;
      bus.scan_done = 1'b0;
      idle(2);
      reset_pulse("rst0");
      // default source: one frame, one load, then nothing pending
      pulse(0, 1, 0, 0, 0);
      idle(49);
      pulse(0, 0, 1, 1, 0);
      idle(3);
      pulse(0, 0, 1, 0, 0);
      idle(2);
      // UART request: S_WAIT keeps the generator running until a UART frame arrives
      bus.mode_req = 1'b1;
      idle(3);
      chk("wait_sel", 32'(bus.sel_uart), 0);
      chk("wait_gen", 32'(bus.gen_enable), 1);
      pulse(1, 0, 0, 0, 0);
      chk("uart_sel", 32'(bus.sel_uart), 1);
      chk("uart_ua", 32'(bus.uart_active), 1);
      chk("uart_gen", 32'(bus.gen_enable), 0);
      idle(2);
      pulse(0, 0, 1, 1, 1);
      // timeout exactly 100 edges after the last valid
      pulse(1, 0, 0, 0, 0);
      idle(99);
      chk("to_99_sel", 32'(bus.sel_uart), 1);
      idle(1);
      chk("to_100_sel", 32'(bus.sel_uart), 0);
      chk("to_100_gen", 32'(bus.gen_enable), 1);
      // valid on the 99th cycle restarts the timeout
      pulse(1, 0, 0, 0, 0);
      pulse(0, 0, 1, 1, 1);
      idle(97);
      pulse(1, 0, 0, 0, 0);
      idle(99);
      chk("rearm_sel", 32'(bus.sel_uart), 1);
      idle(1);
      chk("rearm_to_sel", 32'(bus.sel_uart), 0);
      chk("rearm_drop", 32'(bus.dropped), 0);
      // overwrites of the held UART frame
      for (int i = 0; i < 3; i++) begin
         pulse(1, 0, 0, 0, 0);
         idle(1);
      end
      chk("drop_2", 32'(bus.dropped), 2);
      for (int i = 0; i < 253; i++) begin
         pulse(1, 0, 0, 0, 0);
         idle(1);
      end
      chk("drop_255", 32'(bus.dropped), 255);
      for (int i = 0; i < 47; i++) begin
         pulse(1, 0, 0, 0, 0);
         idle(1);
      end
      chk("drop_sat", 32'(bus.dropped), 255);
      bus.mode_req = 1'b0;
      idle(3);
      chk("back_def_sel", 32'(bus.sel_uart), 0);
      chk("back_def_gen", 32'(bus.gen_enable), 1);
      // valid coincident with scan_done: flag set, load deferred
      pulse(0, 1, 1, 0, 0);
      idle(2);
      pulse(0, 0, 1, 1, 0);
      idle(2);
      // scan_done on the DEF->WAIT edge is skipped, serviced at the next one
      pulse(0, 1, 0, 0, 0);
      idle(2);
      bus.mode_req = 1'b1;
      idle(2);
      pulse(0, 0, 1, 0, 0);
      chk("chg_gen", 32'(bus.gen_enable), 1);
      idle(2);
      pulse(0, 0, 1, 1, 0);
      idle(2);
      // mid-operation reset from S_UART with dropped=5
      reset_pulse("rst1");
      reenter("re1");
      for (int i = 0; i < 5; i++) begin
         pulse(1, 0, 0, 0, 0);
         idle(1);
      end
      chk("drop_5", 32'(bus.dropped), 5);
      reset_pulse("rst2");
      reenter("re2");
      idle(3);
      chk("queue_empty", 32'(exp_q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
